// File: rtl/riscv_wb_pkg.sv
// Shared types and helpers for the register-file write-back path.
package riscv_wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
        return (rd == '0);
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// Load-return queue. When empty, the incoming entry falls through to head and
// can be popped in the same cycle without being stored.
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t push_entry_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            bypass, do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign head_o  = empty_o ? push_entry_i : mem_q[rd_ptr_q];

    assign bypass  = empty_o && push_i && pop_i;
    assign do_push = push_i && !bypass && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Write-port arbiter (ALU vs. queued load returns), output register and load busy scoreboard.
// Optional forwarding outputs are enabled with WB_FWD_BYPASS_EN.
module regfile_writeback_ctrl
    import riscv_wb_pkg::*;
#(
    parameter int N           = 32,
    parameter int MEM_Q_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [N-1:0]          alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [N-1:0]          mem_data,
    input  logic                  iss_load,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  stall,
    output logic                  rf_write,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [N-1:0]          rf_wdata
`ifdef WB_FWD_BYPASS_EN
    ,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [N-1:0]          fwd1_data,
    output logic [N-1:0]          fwd2_data
`endif
);
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [N-1:0]          data;
    } entry_t;

    entry_t                q_head, q_in;
    logic                  q_full, q_empty, q_push, q_pop, q_avail;
    logic                  alu_win, wb_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [N-1:0]          wb_data;

    logic                  rf_write_q, rf_write_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [N-1:0]          rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    assign q_in = '{rd: mem_rd, data: mem_data};

    wb_fifo #(
        .DEPTH   (MEM_Q_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (q_push),
        .push_entry_i (q_in),
        .pop_i        (q_pop),
        .full_o       (q_full),
        .empty_o      (q_empty),
        .head_o       (q_head)
    );

    // A full queue takes priority so load returns can never be starved by the ALU.
    assign mem_ready = !q_full;
    assign alu_ready = !q_full;
    assign q_push    = mem_valid && !q_full;
    assign q_avail   = !q_empty || q_push;
    assign alu_win   = alu_valid && !q_full;
    assign q_pop     = q_avail && !alu_win;

    assign wb_rd   = alu_win ? alu_rd   : q_head.rd;
    assign wb_data = alu_win ? alu_data : q_head.data;
    assign wb_en   = (alu_win || q_pop) && !is_x0(wb_rd);

    always_comb begin
        rf_write_d = wb_en;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_en) begin
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
        end
    end

    // Set is applied after clear so a same-cycle reissue of rd stays busy.
    always_comb begin
        busy_d = busy_q;
        if (q_pop && !alu_win && !is_x0(q_head.rd)) busy_d[q_head.rd] = 1'b0;
        if (iss_load && !is_x0(iss_rd))              busy_d[iss_rd]    = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_q <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_write_q <= rf_write_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign stall = (!is_x0(q_rs1) && busy_q[q_rs1]) || (!is_x0(q_rs2) && busy_q[q_rs2]);

    assign rf_write = rf_write_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_FWD_BYPASS_EN
    assign fwd1_hit  = rf_write_q && (rf_waddr_q == q_rs1);
    assign fwd2_hit  = rf_write_q && (rf_waddr_q == q_rs2);
    assign fwd1_data = rf_wdata_q;
    assign fwd2_data = rf_wdata_q;
`endif
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed bench for regfile_writeback_ctrl with a queue-level reference model.
module tb_regfile_writeback_ctrl;
    localparam int N     = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid, mem_valid, iss_load;
    logic [4:0]  alu_rd, mem_rd, iss_rd, q_rs1, q_rs2;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, stall, rf_write;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    regfile_writeback_ctrl #(.N(N), .MEM_Q_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_load(iss_load), .iss_rd(iss_rd), .q_rs1(q_rs1), .q_rs2(q_rs2),
        .stall(stall), .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of pending loads, a busy set, and the expected write.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          mbusy[32];
    bit          m_write;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    ent_t        w;
    bit          have, is_load, full;
    logic [4:0]  wlog[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            m_write = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            full    = (mq.size() == DEPTH);
            have    = 1'b0;
            is_load = 1'b0;
            if (mem_valid && !full) mq.push_back('{mem_rd, mem_data});
            if (alu_valid && !full) begin
                w    = '{alu_rd, alu_data};
                have = 1'b1;
            end else if (mq.size() > 0) begin
                w       = mq.pop_front();
                have    = 1'b1;
                is_load = 1'b1;
            end
            m_write = have && (w.rd != 5'd0);
            if (m_write) begin
                m_waddr = w.rd;
                m_wdata = w.data;
            end
            if (have && is_load && w.rd != 5'd0) mbusy[w.rd] = 1'b0;
            if (iss_load && iss_rd != 5'd0)      mbusy[iss_rd] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("rf_write", {31'd0, rf_write}, {31'd0, m_write});
            if (m_write) begin
                check("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
                check("rf_wdata", rf_wdata, m_wdata);
            end
            if (rf_write) wlog.push_back(rf_waddr);
            check("stall", {31'd0, stall},
                  {31'd0, ((q_rs1 != 0) && mbusy[q_rs1]) || ((q_rs2 != 0) && mbusy[q_rs2])});
            check("mem_ready", {31'd0, mem_ready}, {31'd0, mq.size() < DEPTH});
            check("alu_ready", {31'd0, alu_ready}, {31'd0, mq.size() < DEPTH});
        end
    end

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        iss_load  = 0; iss_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1; alu_rd = rd; alu_data = d;
    endtask

    task automatic mem(input logic [4:0] rd, input logic [31:0] d);
        mem_valid = 1; mem_rd = rd; mem_data = d;
    endtask

    initial begin
        idle();
        q_rs1 = 0; q_rs2 = 0;
        #2;
        check("reset rf_write", {31'd0, rf_write}, 32'd0);
        check("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
        check("reset rf_wdata", rf_wdata, 32'd0);
        check("reset mem_ready", {31'd0, mem_ready}, 32'd1);
        check("reset alu_ready", {31'd0, alu_ready}, 32'd1);
        #10;
        rst = 0;
        chk_en = 1;
        tick();

        // ALU write lands one cycle later, for one cycle only
        alu(5'd5, 32'hA5A5A5A5);
        tick();
        idle();
        check("t1 write", {31'd0, rf_write}, 32'd1);
        check("t1 waddr", {27'd0, rf_waddr}, 32'd5);
        check("t1 wdata", rf_wdata, 32'hA5A5A5A5);
        tick();
        check("t1 write drop", {31'd0, rf_write}, 32'd0);

        // load-use hazard
        iss_load = 1; iss_rd = 5'd7;
        tick();
        idle();
        q_rs1 = 5'd7;
        #1;
        check("t2 stall a", {31'd0, stall}, 32'd1);
        tick();
        check("t2 stall b", {31'd0, stall}, 32'd1);
        mem(5'd7, 32'h1234);
        #1;
        check("t2 stall c", {31'd0, stall}, 32'd1);
        tick();
        idle();
        #1;
        check("t2 write", {31'd0, rf_write}, 32'd1);
        check("t2 waddr", {27'd0, rf_waddr}, 32'd7);
        check("t2 wdata", rf_wdata, 32'h1234);
        check("t2 stall clr", {31'd0, stall}, 32'd0);
        tick();
        q_rs1 = 0;

        // contention: ALU keeps winning until the queue fills
        wlog.delete();
        alu(5'd10, 32'h10); mem(5'd11, 32'h11);
        tick();
        alu(5'd12, 32'h12); mem(5'd13, 32'h13);
        tick();
        mem_valid = 0;
        alu(5'd14, 32'h14);
        #1;
        check("t3 mem_ready full", {31'd0, mem_ready}, 32'd0);
        check("t3 alu_ready full", {31'd0, alu_ready}, 32'd0);
        tick();
        tick();
        idle();
        tick();
        tick();
        tick();
        check("t3 write count", wlog.size(), 32'd5);
        if (wlog.size() == 5) begin
            check("t3 order 0", {27'd0, wlog[0]}, 32'd10);
            check("t3 order 1", {27'd0, wlog[1]}, 32'd12);
            check("t3 order 2", {27'd0, wlog[2]}, 32'd11);
            check("t3 order 3", {27'd0, wlog[3]}, 32'd14);
            check("t3 order 4", {27'd0, wlog[4]}, 32'd13);
        end

        // x0 results are consumed but never written
        alu(5'd0, 32'hDEAD);
        tick();
        idle();
        check("t4 alu x0", {31'd0, rf_write}, 32'd0);
        mem(5'd0, 32'hBEEF);
        iss_load = 1; iss_rd = 5'd0;
        tick();
        idle();
        q_rs2 = 5'd7;
        #1;
        check("t4 mem x0", {31'd0, rf_write}, 32'd0);
        check("t4 stall", {31'd0, stall}, 32'd0);
        tick();
        q_rs2 = 0;

        // same-cycle set/clear of busy[9]
        iss_load = 1; iss_rd = 5'd9;
        tick();
        idle();
        mem(5'd9, 32'h99);
        iss_load = 1; iss_rd = 5'd9;
        tick();
        idle();
        q_rs1 = 5'd9;
        #1;
        check("t5 write", {31'd0, rf_write}, 32'd1);
        check("t5 waddr", {27'd0, rf_waddr}, 32'd9);
        check("t5 stall kept", {31'd0, stall}, 32'd1);
        mem(5'd9, 32'h98);
        tick();
        idle();
        #1;
        check("t5 stall clr", {31'd0, stall}, 32'd0);
        tick();

        // reset mid-operation
        iss_load = 1; iss_rd = 5'd3;
        tick();
        idle();
        q_rs1 = 5'd3;
        alu(5'd22, 32'h22); mem(5'd20, 32'h20);
        tick();
        alu(5'd23, 32'h23); mem(5'd21, 32'h21);
        tick();
        idle();
        #1;
        check("t6 full before rst", {31'd0, mem_ready}, 32'd0);
        check("t6 stall before rst", {31'd0, stall}, 32'd1);
        #1;
        rst = 1;
        #1;
        check("t6 rst mem_ready", {31'd0, mem_ready}, 32'd1);
        check("t6 rst rf_write", {31'd0, rf_write}, 32'd0);
        check("t6 rst stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 0;
        alu(5'd3, 32'hCAFE);
        tick();
        idle();
        check("t6 write", {31'd0, rf_write}, 32'd1);
        check("t6 waddr", {27'd0, rf_waddr}, 32'd3);
        check("t6 wdata", rf_wdata, 32'hCAFE);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
